// File: rtl/apb_to_i2c_bridge_if.sv
// APB3 bus bundle for the APB-to-I2C bridge.
interface apb_to_i2c_bridge_if #(
    parameter int ADDR_W = 8
);
    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [7:0]        PWDATA;
    logic              PREADY;
    logic [7:0]        PRDATA;

    modport master (
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  PREADY, PRDATA
    );

    modport slave (
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output PREADY, PRDATA
    );
endinterface

// File: rtl/apb_to_i2c_bridge.sv
// APB3 slave with a single-master I2C engine: START, address byte, one data byte, STOP.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | both lines released, waiting for a START command
// S_START    | waits out the post-STOP bus hold, then SDA falls with SCL high
// S_ADDR     | 8 address/direction bits, MSB first
// S_ADDR_ACK | SDA released, slave ACK sampled; NACK jumps to S_STOP
// S_DATA     | write: TXDR shifted out; read: 8 bits shifted in
// S_DATA_ACK | write: slave ACK sampled; read: master NACKs (SDA released)
// S_STOP     | SDA low under low SCL, SCL released, then SDA released
module apb_to_i2c_bridge #(
    parameter logic [7:0] PRESCALE_RST = 8'd4,
    parameter int         ADDR_W       = 8
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    apb_to_i2c_bridge_if.slave apb,
    inout  wire                i2c_scl,
    inout  wire                i2c_sda
);

    localparam logic [ADDR_W-1:0] A_PRER = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_SADR = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_TXDR = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_RXDR = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_CMD  = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(6);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  prer_q, prer_d, sadr_q, sadr_d, txdr_q, txdr_d;
    logic [7:0]  rxdr_q, rxdr_d, shreg_q, shreg_d, tcnt_q, tcnt_d;
    logic        en_q, en_d, nack_q, nack_d, done_q, done_d, smp_q, smp_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic [10:0] hold_q, hold_d;

    logic acc, wr, busy, run, tick, smp_tick, bit_end, start_acc, abort;
    logic rd_dir, sda_in, nack_set, done_set, scl_low, sda_low;

    assign acc       = apb.PSELx & apb.PENABLE;
    assign wr        = acc & apb.PWRITE;
    assign busy      = (state_q != S_IDLE);
    assign abort     = busy & ~en_q;
    assign rd_dir    = sadr_q[0];
    assign sda_in    = i2c_sda;
    // The quarter timer is frozen while the bus-free hold after a STOP is still counting.
    assign run       = busy && !(state_q == S_START && hold_q != 11'd0);
    assign tick      = run && (tcnt_q == 8'd0);
    assign smp_tick  = tick && (qtr_q == 2'd2);
    assign bit_end   = tick && (qtr_q == 2'd3);
    assign start_acc = wr && (apb.PADDR == A_CMD) && apb.PWDATA[0] && en_q && !busy;

    assign apb.PREADY = acc;
    assign i2c_scl    = scl_low ? 1'b0 : 1'bz;
    assign i2c_sda    = sda_low ? 1'b0 : 1'bz;

    // Read mux: combinational during the read access phase only.
    always_comb begin
        apb.PRDATA = 8'h00;
        if (acc && !apb.PWRITE) begin
            case (apb.PADDR)
                A_PRER:  apb.PRDATA = prer_q;
                A_CTRL:  apb.PRDATA = {7'b0, en_q};
                A_SADR:  apb.PRDATA = sadr_q;
                A_TXDR:  apb.PRDATA = txdr_q;
                A_RXDR:  apb.PRDATA = rxdr_q;
                A_STAT:  apb.PRDATA = {5'b0, done_q, nack_q, busy};
                default: apb.PRDATA = 8'h00;
            endcase
        end
    end

    // Register file: writes, W1C status, and status set events (set beats clear).
    always_comb begin
        prer_d = prer_q;
        en_d   = en_q;
        sadr_d = sadr_q;
        txdr_d = txdr_q;
        nack_d = nack_q;
        done_d = done_q;
        if (wr) begin
            case (apb.PADDR)
                A_PRER:  if (!busy) prer_d = apb.PWDATA;
                A_CTRL:  en_d = apb.PWDATA[0];
                A_SADR:  if (!busy) sadr_d = apb.PWDATA;
                A_TXDR:  if (!busy) txdr_d = apb.PWDATA;
                A_STAT: begin
                    if (apb.PWDATA[1]) nack_d = 1'b0;
                    if (apb.PWDATA[2]) done_d = 1'b0;
                end
                default: ;
            endcase
        end
        if (start_acc) begin
            nack_d = 1'b0;
            done_d = 1'b0;
        end
        if (nack_set && !abort) nack_d = 1'b1;
        if (done_set) done_d = 1'b1;
        if (abort) done_d = 1'b0;
    end

    // Bit timing and transaction sequencing.
    always_comb begin
        state_d  = state_q;
        qtr_d    = qtr_q;
        tcnt_d   = tcnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        rxdr_d   = rxdr_q;
        smp_d    = smp_q;
        hold_d   = (hold_q != 11'd0) ? hold_q - 11'd1 : hold_q;
        nack_set = 1'b0;
        done_set = 1'b0;

        if (!run) begin
            tcnt_d = prer_q;
            qtr_d  = 2'd0;
        end else if (tcnt_q == 8'd0) begin
            tcnt_d = prer_q;
            qtr_d  = qtr_q + 2'd1;
        end else begin
            tcnt_d = tcnt_q - 8'd1;
        end

        if (smp_tick) smp_d = sda_in;

        case (state_q)
            S_IDLE: if (start_acc) state_d = S_START;
            S_START: if (bit_end) begin
                state_d = S_ADDR;
                bit_d   = 3'd7;
                shreg_d = sadr_q;
            end
            S_ADDR: if (bit_end) begin
                shreg_d = {shreg_q[6:0], 1'b0};
                if (bit_q == 3'd0) state_d = S_ADDR_ACK;
                else               bit_d   = bit_q - 3'd1;
            end
            S_ADDR_ACK: if (bit_end) begin
                if (smp_q) begin
                    nack_set = 1'b1;
                    state_d  = S_STOP;
                end else begin
                    state_d = S_DATA;
                    bit_d   = 3'd7;
                    shreg_d = txdr_q;
                end
            end
            S_DATA: begin
                if (rd_dir && smp_tick) shreg_d = {shreg_q[6:0], sda_in};
                if (bit_end) begin
                    if (!rd_dir) shreg_d = {shreg_q[6:0], 1'b0};
                    if (bit_q == 3'd0) begin
                        state_d = S_DATA_ACK;
                        if (rd_dir) rxdr_d = shreg_q;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            S_DATA_ACK: if (bit_end) begin
                if (!rd_dir && smp_q) nack_set = 1'b1;
                state_d = S_STOP;
            end
            S_STOP: if (bit_end) begin
                state_d  = S_IDLE;
                done_set = 1'b1;
                hold_d   = 11'(({3'b000, prer_q} + 11'd1) << 2);
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) state_d = S_IDLE;
    end

    // Open-drain line drivers; SCL low in quarters 0-1 of every clocked bit.
    always_comb begin
        scl_low = 1'b0;
        sda_low = 1'b0;
        case (state_q)
            S_START: sda_low = qtr_q[1];
            S_ADDR: begin
                scl_low = ~qtr_q[1];
                sda_low = ~shreg_q[7];
            end
            S_ADDR_ACK, S_DATA_ACK: scl_low = ~qtr_q[1];
            S_DATA: begin
                scl_low = ~qtr_q[1];
                sda_low = ~rd_dir & ~shreg_q[7];
            end
            S_STOP: begin
                scl_low = ~qtr_q[1];
                sda_low = (qtr_q != 2'd3);
            end
            default: ;
        endcase
    end

    // State and register flops.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= S_IDLE;
            prer_q  <= PRESCALE_RST;
            en_q    <= 1'b0;
            sadr_q  <= 8'h00;
            txdr_q  <= 8'h00;
            rxdr_q  <= 8'h00;
            nack_q  <= 1'b0;
            done_q  <= 1'b0;
            smp_q   <= 1'b0;
            shreg_q <= 8'h00;
            tcnt_q  <= PRESCALE_RST;
            qtr_q   <= 2'd0;
            bit_q   <= 3'd0;
            hold_q  <= 11'd0;
        end else begin
            state_q <= state_d;
            prer_q  <= prer_d;
            en_q    <= en_d;
            sadr_q  <= sadr_d;
            txdr_q  <= txdr_d;
            rxdr_q  <= rxdr_d;
            nack_q  <= nack_d;
            done_q  <= done_d;
            smp_q   <= smp_d;
            shreg_q <= shreg_d;
            tcnt_q  <= tcnt_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_apb_to_i2c_bridge.sv
// Directed plus randomized bench for apb_to_i2c_bridge with an I2C slave model at address 0x50.
module tb_apb_to_i2c_bridge;

    logic pclk = 1'b0;
    logic presetn = 1'b0;
    wire  scl, sda;

    int vectors = 0;
    int miscompares = 0;

    apb_to_i2c_bridge_if #(.ADDR_W(8)) bus ();

    apb_to_i2c_bridge #(.PRESCALE_RST(8'd4), .ADDR_W(8)) dut (
        .PCLK    (pclk),
        .PRESETn (presetn),
        .apb     (bus),
        .i2c_scl (scl),
        .i2c_sda (sda)
    );

    pullup (scl);
    pullup (sda);

    always #5 pclk = ~pclk;

    // I2C slave model: bus-level view of the transaction, observed on PCLK falling edges.
    logic       slave_low = 1'b0;
    logic [7:0] slave_tx = 8'h00;
    logic       scl_p = 1'b1, sda_p = 1'b1;
    int         cyc = 0, last_rise = 0, per_meas = 0;
    int         bitcnt = 0, byteidx = 0;
    int         starts = 0, stops = 0, rises = 0;
    logic [7:0] sh = 8'h00, rx_addr = 8'h00, rx_data = 8'h00;
    logic       mst_ack = 1'b0, addressed = 1'b0, slv_rd = 1'b0;

    assign sda = slave_low ? 1'b0 : 1'bz;

    always @(negedge pclk) begin
        logic s, d;
        logic [2:0] idx;
        s = scl;
        d = sda;
        cyc++;
        if (scl_p && s && sda_p && !d) begin
            starts++;
            bitcnt = 0;
            byteidx = 0;
            addressed = 1'b0;
            slave_low = 1'b0;
        end else if (scl_p && s && !sda_p && d) begin
            stops++;
            slave_low = 1'b0;
        end else if (!scl_p && s) begin
            if (byteidx == 0 && bitcnt == 1) per_meas = cyc - last_rise;
            last_rise = cyc;
            rises++;
            if (bitcnt < 8) sh = {sh[6:0], d};
            else if (byteidx == 1) mst_ack = d;
            bitcnt++;
            if (bitcnt == 8) begin
                if (byteidx == 0) begin
                    rx_addr = sh;
                    addressed = (sh[7:1] == 7'h50);
                    slv_rd = sh[0];
                end else begin
                    rx_data = sh;
                end
            end
        end else if (scl_p && !s) begin
            if (bitcnt == 9) begin
                bitcnt = 0;
                byteidx++;
            end
            slave_low = 1'b0;
            if (addressed) begin
                if (bitcnt == 8 && (byteidx == 0 || !slv_rd)) begin
                    slave_low = 1'b1;
                end else if (byteidx == 1 && slv_rd && bitcnt < 8) begin
                    idx = 3'(7 - bitcnt);
                    slave_low = ~slave_tx[idx];
                end
            end
        end
        scl_p = s;
        sda_p = d;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge pclk);
        bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = a; bus.PWDATA = d;
        @(negedge pclk);
        bus.PENABLE = 1'b1;
        #1 check("pready_wr", 32'(bus.PREADY), 32'd1);
        @(negedge pclk);
        bus.PSELx = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge pclk);
        bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
        #1 check("pready_setup", 32'(bus.PREADY), 32'd0);
        @(negedge pclk);
        bus.PENABLE = 1'b1;
        #1 check("pready_rd", 32'(bus.PREADY), 32'd1);
        d = bus.PRDATA;
        @(negedge pclk);
        bus.PSELx = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] v;
        apb_read(a, v);
        check(tag, 32'(v), 32'(exp));
    endtask

    int base_starts, base_stops, base_rises;

    task automatic xfer_begin(input logic [7:0] p, input logic [7:0] s,
                              input logic [7:0] t, input logic [7:0] x);
        slave_tx = x;
        apb_write(8'h00, p);
        apb_write(8'h02, s);
        apb_write(8'h03, t);
        apb_write(8'h01, 8'h01);
        base_starts = starts;
        base_stops  = stops;
        base_rises  = rises;
        apb_write(8'h05, 8'h01);
    endtask

    // Reference: expectations derived from the transaction rules, not from the RTL structure.
    task automatic xfer_end(input logic [7:0] p, input logic [7:0] s,
                            input logic [7:0] t, input logic [7:0] x);
        logic [7:0] st;
        int n;
        logic acked, rd;
        acked = (s[7:1] == 7'h50);
        rd = s[0];
        n = 0;
        apb_read(8'h06, st);
        while (!st[2] && n < 600) begin
            apb_read(8'h06, st);
            n++;
        end
        check("done_seen", 32'(st[2]), 32'd1);
        check("stat", 32'(st), acked ? 32'h04 : 32'h06);
        check("start_count", 32'(starts - base_starts), 32'd1);
        check("stop_count", 32'(stops - base_stops), 32'd1);
        check("scl_pulses", 32'(rises - base_rises), acked ? 32'd19 : 32'd10);
        check("scl_period", 32'(per_meas), 32'(4 * (int'(p) + 1)));
        check("addr_byte", 32'(rx_addr), 32'(s));
        if (acked && !rd) check("wr_data", 32'(rx_data), 32'(t));
        if (acked && rd) begin
            rd_chk("rxdr", 8'h04, x);
            check("master_nack", 32'(mst_ack), 32'd1);
        end
        apb_write(8'h06, 8'h06);
        rd_chk("stat_w1c", 8'h06, 8'h00);
    endtask

    initial begin
        logic ok;
        bus.PSELx = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = 8'h00; bus.PWDATA = 8'h00;

        // Reset state
        repeat (3) @(negedge pclk);
        #1;
        check("rst_scl", 32'(scl), 32'd1);
        check("rst_sda", 32'(sda), 32'd1);
        check("rst_pready", 32'(bus.PREADY), 32'd0);
        check("rst_prdata", 32'(bus.PRDATA), 32'd0);
        presetn = 1'b1;
        rd_chk("rst_prer", 8'h00, 8'h04);
        rd_chk("rst_ctrl", 8'h01, 8'h00);
        rd_chk("rst_sadr", 8'h02, 8'h00);
        rd_chk("rst_txdr", 8'h03, 8'h00);
        rd_chk("rst_stat", 8'h06, 8'h00);

        // Register access
        apb_write(8'h00, 8'h01);
        apb_write(8'h02, 8'hA0);
        apb_write(8'h03, 8'h5A);
        rd_chk("prer_rb", 8'h00, 8'h01);
        rd_chk("sadr_rb", 8'h02, 8'hA0);
        rd_chk("txdr_rb", 8'h03, 8'h5A);
        rd_chk("unmapped_rd", 8'h07, 8'h00);
        rd_chk("cmd_rd", 8'h05, 8'h00);
        apb_write(8'h04, 8'h77);
        rd_chk("rxdr_ro", 8'h04, 8'h00);

        // START ignored while EN=0
        apb_write(8'h05, 8'h01);
        rd_chk("start_no_en", 8'h06, 8'h00);
        repeat (20) @(negedge pclk);
        #1;
        check("idle_scl", 32'(scl), 32'd1);
        check("idle_sda", 32'(sda), 32'd1);

        // Write transfer with busy protection
        xfer_begin(8'h01, 8'hA0, 8'hA5, 8'h00);
        rd_chk("busy", 8'h06, 8'h01);
        apb_write(8'h03, 8'hFF);
        apb_write(8'h05, 8'h01);
        rd_chk("txdr_locked", 8'h03, 8'hA5);
        xfer_end(8'h01, 8'hA0, 8'hA5, 8'h00);

        // Read transfer
        xfer_begin(8'h01, 8'hA1, 8'h00, 8'h3C);
        xfer_end(8'h01, 8'hA1, 8'h00, 8'h3C);

        // Address NACK
        xfer_begin(8'h01, 8'h44, 8'h00, 8'h00);
        xfer_end(8'h01, 8'h44, 8'h00, 8'h00);

        // Randomized transfers
        for (int i = 0; i < 5; i++) begin
            logic [7:0] p, s, t, x;
            p = 8'($urandom_range(0, 3));
            s = 8'($urandom);
            if ($urandom_range(0, 2) != 0) s[7:1] = 7'h50;
            else if (s[7:1] == 7'h50) s[1] = ~s[1];
            t = 8'($urandom);
            x = 8'($urandom);
            xfer_begin(p, s, t, x);
            xfer_end(p, s, t, x);
        end

        // Abort by clearing EN mid-address
        xfer_begin(8'h01, 8'hA0, 8'h3C, 8'h00);
        ok = 1'b0;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge pclk);
            if (rises - base_rises >= 3) ok = 1'b1;
        end
        check("abort_reached", 32'(ok), 32'd1);
        apb_write(8'h01, 8'h00);
        rd_chk("abort_stat", 8'h06, 8'h00);
        #1;
        check("abort_scl", 32'(scl), 32'd1);
        check("abort_sda", 32'(sda), 32'd1);

        // Reset during the data phase
        xfer_begin(8'h01, 8'hA0, 8'hA5, 8'h00);
        ok = 1'b0;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge pclk);
            if (byteidx == 1 && bitcnt >= 3) ok = 1'b1;
        end
        check("data_phase_reached", 32'(ok), 32'd1);
        #2 presetn = 1'b0;
        #1;
        check("rstmid_scl", 32'(scl), 32'd1);
        check("rstmid_sda", 32'(sda), 32'd1);
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        rd_chk("rstmid_prer", 8'h00, 8'h04);
        rd_chk("rstmid_ctrl", 8'h01, 8'h00);
        rd_chk("rstmid_sadr", 8'h02, 8'h00);
        rd_chk("rstmid_txdr", 8'h03, 8'h00);
        rd_chk("rstmid_stat", 8'h06, 8'h00);
        xfer_begin(8'h04, 8'hA0, 8'h69, 8'h00);
        xfer_end(8'h04, 8'hA0, 8'h69, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_to_i2c_bridge.md
Name: apb_to_i2c_bridge

Overview:
APB3 slave peripheral containing a single-master I2C controller.
- Software programs prescaler, slave address, direction and data through APB registers, then issues a START command.
- The block runs one complete I2C transaction on open-drain SCL/SDA: START, address byte, one data byte, STOP.
- It sits between the APB fabric and an external I2C bus with pull-ups.

Parameters:
PRESCALE_RST, 8'd4, reset value of PRER register
ADDR_W, 8, PADDR width

Ports:
PCLK  input  1  single clock for APB and I2C engine
PRESETn  input  1  asynchronous active-low reset
PSELx  input  1  APB select
PENABLE  input  1  APB enable (access phase)
PWRITE  input  1  1=write, 0=read
PADDR  input  ADDR_W  register address
PWDATA  input  8  write data
PREADY  output  1  transfer ready
PRDATA  output  8  read data
i2c_scl  inout  1  I2C clock, open-drain (drives 0 or Z)
i2c_sda  inout  1  I2C data, open-drain (drives 0 or Z)

Behaviour:
- APB: zero wait states. PREADY=1 whenever PSELx&PENABLE, else 0.
- Writes commit on PCLK edge with PSELx&PENABLE&PWRITE.
- PRDATA is combinational from the addressed register during read access phase, 0 otherwise.
- Unmapped addresses: reads return 0x00, writes ignored.
- Register map:
  - 0x00 PRER rw: prescale.
  - 0x01 CTRL rw: bit0 EN.
  - 0x02 SADR rw: [7:1] slave address, [0] R/W (1=read).
  - 0x03 TXDR rw: write-data byte.
  - 0x04 RXDR ro: received byte.
  - 0x05 CMD wo: bit0 START, self-clearing, reads 0.
  - 0x06 STAT: bit0 BUSY ro; bit1 NACK, sticky, W1C; bit2 DONE, sticky, W1C.
- Reset values: PRER=PRESCALE_RST; all other registers 0. SCL/SDA released (Z). FSM in IDLE. PRDATA=0, PREADY=0.
- Timing: each I2C bit spans 4 quarter-phases; one quarter = PRER+1 PCLK cycles. SCL period = 4*(PRER+1) PCLK cycles.
  - SCL is low in quarters 0-1 and high in quarters 2-3.
  - SDA changes only in quarter 0.
  - Receive sampling occurs at the end of quarter 2.
- No clock stretching and no multi-master arbitration.
- START accepted only when EN=1 and BUSY=0; otherwise ignored. Acceptance sets BUSY and clears DONE and NACK.
- While BUSY, writes to PRER, SADR and TXDR are ignored.
- FSM states:
  - IDLE: both lines released.
  - START: SDA falls while SCL high (one bit time).
  - ADDR: 8 bits of SADR, MSB first.
  - ADDR_ACK: SDA released, sampled. If 1 → set NACK, go to STOP.
  - DATA:
    - Write: TXDR MSB first, SDA driven.
    - Read: SDA released, 8 bits shifted in MSB first.
  - DATA_ACK:
    - Write: sample ACK; 1 sets NACK.
    - Read: master drives NACK (SDA released); RXDR updated with the received byte on entry.
  - STOP: SDA low while SCL low, SCL released, then SDA released while SCL high.
  - → IDLE with BUSY=0, DONE=1.
- Clearing EN mid-transfer aborts at the next PCLK edge: lines released, FSM to IDLE, BUSY=0, DONE=0, NACK unchanged.
- Async reset mid-transfer: immediate return to reset state; lines released within the reset assertion.
- Simultaneous W1C write to STAT and the DONE set event: the set wins.
- Bus hold after STOP: minimum one bit time before the next START is driven.

Test Plan:
- Register access: write PRER=0x01, SADR=0xA0, TXDR=0x5A and read each back. Read 0x07 → 0x00. Read CMD → 0x00. PREADY=1 in every access phase, zero wait states.
- Write transfer: PRER=1, EN=1, SADR=0xA0 (addr 0x50, write), TXDR=0xA5, CMD=1. Bus must show START, 0xA0, ACK, 0xA5, ACK, STOP; SCL period 8 PCLK. STAT ends 0x04; slave model receives 0xA5.
- Read transfer: SADR=0xA1, slave model returns 0x3C. RXDR=0x3C, master NACKs the data byte, STAT=0x04.
- Address NACK: SADR=0x44 (no slave responds). No data byte is clocked; STOP follows ADDR_ACK; STAT=0x06. Writing 0x06 to STAT clears it to 0x00.
- Protection: CMD=1 with EN=0 gives BUSY=0 and lines idle. While BUSY, TXDR write 0xFF is ignored and a second CMD=1 is ignored.
- Abort/reset: assert PRESETn=0 during the DATA phase. SCL/SDA go Z, all registers reset, PRER=PRESCALE_RST. A subsequent transfer completes normally.
